// File: rtl/byte_striping_if.sv
// byte_striping_if: stream input and striped lane output bundle for byte_striping
interface byte_striping_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       flush;
  logic [7:0] Lane_0;
  logic [7:0] Lane_1;
  logic [7:0] Lane_2;
  logic [7:0] Lane_3;
  logic       lanes_valid;
  logic [3:0] pad_mask;
  logic [1:0] ctr_3;
  modport master (
    output in_byte, in_valid, flush,
    input  Lane_0, Lane_1, Lane_2, Lane_3, lanes_valid, pad_mask, ctr_3
  );
  modport slave (
    input  in_byte, in_valid, flush,
    output Lane_0, Lane_1, Lane_2, Lane_3, lanes_valid, pad_mask, ctr_3
  );
endinterface

// File: rtl/byte_striping.sv
// byte_striping: stripes a byte stream round-robin over four lanes, flush pads partial groups
module byte_striping #(
  parameter logic [7:0] PAD = 8'hBC
) (
  input logic          clk250k,
  input logic          reset_L,
  byte_striping_if.slave bus
);
  logic [23:0] r_buf;
  logic [1:0]  r_ctr;
  logic [31:0] r_lanes;
  logic        r_valid;
  logic [3:0]  r_mask;
  logic        w_emit;
  logic [2:0]  w_cnt;
  logic [31:0] w_ext;
  logic [31:0] w_lanes;
  logic [3:0]  w_mask;
  assign w_emit = (bus.in_valid && r_ctr == 2'd3) || (bus.flush && (bus.in_valid || r_ctr != 2'd0));
  assign w_cnt  = {1'b0, r_ctr} + {2'b00, bus.in_valid};
  assign w_ext  = {PAD, r_buf};
  // lane k: staged byte below ctr, the incoming byte at ctr, PAD beyond
  always_comb begin
    w_lanes = '0;
    w_mask  = '0;
    for (int k = 0; k < 4; k++) begin
      w_lanes[8*k +: 8] = (3'(k) < {1'b0, r_ctr}) ? w_ext[8*k +: 8] :
                          (3'(k) == {1'b0, r_ctr} && bus.in_valid) ? bus.in_byte : PAD;
      w_mask[k] = 3'(k) >= w_cnt;
    end
  end
  always_ff @(posedge clk250k or negedge reset_L) begin
    if (!reset_L) begin
      r_buf   <= '0;
      r_ctr   <= '0;
      r_lanes <= '0;
      r_valid <= 1'b0;
      r_mask  <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_lanes <= w_lanes;
        r_mask  <= w_mask;
        r_ctr   <= '0;
      end else if (bus.in_valid) begin
        for (int k = 0; k < 3; k++)
          if (r_ctr == 2'(k)) r_buf[8*k +: 8] <= bus.in_byte;
        r_ctr <= r_ctr + 2'd1;
      end
    end
  end
  assign bus.Lane_0      = r_lanes[7:0];
  assign bus.Lane_1      = r_lanes[15:8];
  assign bus.Lane_2      = r_lanes[23:16];
  assign bus.Lane_3      = r_lanes[31:24];
  assign bus.lanes_valid = r_valid;
  assign bus.pad_mask    = r_mask;
  assign bus.ctr_3       = r_ctr;
endmodule
